// File: rtl/lut_mult_pipe.sv
// lut_mult_pipe: pipelined multi-lane fixed-point multiplier for the quantisation stage.
//
// Each accepted beat carries LANES signed samples and one coefficient index. Every sample is
// multiplied by the unsigned coefficient read from a runtime-loadable table. FRAC bits are
// then rounded off (round half toward +inf), and the result is emitted over a valid/ready stream.
//
// Pipeline (3 cycles accept -> m_valid):
//   S1 samples + table lookup, S2 full signed product, S3 round + narrow (output register).
//
// Optional feature (define LUT_MULT_SAT_EN):
//   Out-of-range results clamp and set sat_flag. An internal 32-bit saturating counter
//   sat_count counts output beats with any lane saturated. When undefined, results wrap to
//   IN_W bits and sat_flag is tied to 0.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   coef_we/coef_addr/coef_wdata coefficient table write port (registered)
//   s_valid/s_ready/s_idx/s_data input stream, lane i at s_data[i*IN_W +: IN_W]
//   m_valid/m_ready/m_data       output stream, same lane packing
//   sat_flag                     per-lane saturation flags for the current m_data beat

module lut_mult_pipe #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned CONST_W = 22,
    parameter int unsigned FRAC    = 15,
    parameter int unsigned LANES   = 8,
    parameter int unsigned DEPTH   = 64,
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic [CONST_W-1:0]      coef_wdata,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [AW-1:0]           s_idx,
    input  logic [LANES*IN_W-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*IN_W-1:0]   m_data,
    output logic [LANES-1:0]        sat_flag
);

    localparam int unsigned PW = IN_W + CONST_W + 1;
    localparam int unsigned RW = PW - FRAC;
    localparam logic signed [PW-1:0] Half = PW'(1) << (FRAC - 1);

    // Coefficient table: deliberately not reset, software reloads it.
    logic [CONST_W-1:0] coef_tab [DEPTH];
    logic               wr_ok;
    logic               rd_ok;
    logic [CONST_W-1:0] coef_rd;

    assign wr_ok = (32'(coef_addr) < DEPTH);
    assign rd_ok = (32'(s_idx) < DEPTH);

    always_ff @(posedge clk) begin
        if (coef_we && wr_ok) begin
            coef_tab[coef_addr] <= coef_wdata;
        end
    end

    // Read happens before the write lands, so a same-cycle write is seen by the next beat only.
    always_comb begin
        coef_rd = '0;
        if (rd_ok) begin
            coef_rd = coef_tab[s_idx];
        end
    end

    // Handshake chain: each stage loads when empty or when its successor advances.
    logic v1_q, v2_q, m_valid_q;
    logic adv1, adv2, adv3;

    assign adv3    = !m_valid_q || m_ready;
    assign adv2    = !v2_q || adv3;
    assign adv1    = !v1_q || adv2;
    assign s_ready = adv1;

    // S1: samples and coefficient
    logic [LANES*IN_W-1:0] s1_data_q;
    logic [CONST_W-1:0]    s1_coef_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            s1_data_q <= '0;
            s1_coef_q <= '0;
        end else if (adv1) begin
            v1_q <= s_valid;
            if (s_valid) begin
                s1_data_q <= s_data;
                s1_coef_q <= coef_rd;
            end
        end
    end

    // S2: full-width signed products, coefficient zero-extended
    logic signed [PW-1:0] prod_d    [LANES];
    logic signed [PW-1:0] s2_prod_q [LANES];
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] c_ext;

    always_comb begin
        c_ext  = PW'($signed({1'b0, s1_coef_q}));
        a_ext  = '0;
        prod_d = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            a_ext     = PW'($signed(s1_data_q[i*IN_W +: IN_W]));
            prod_d[i] = a_ext * c_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            s2_prod_q <= '{default: '0};
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_prod_q <= prod_d;
            end
        end
    end

    // S3: round half toward +inf, then narrow
    logic [LANES*IN_W-1:0] res_d;
    logic signed [PW-1:0]  rnd;
`ifdef LUT_MULT_SAT_EN
    logic signed [RW-1:0]  rsh;
    logic [LANES-1:0]      sat_d;
`endif

    always_comb begin
        res_d = '0;
        rnd   = '0;
`ifdef LUT_MULT_SAT_EN
        rsh   = '0;
        sat_d = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            rnd = s2_prod_q[i] + Half;
`ifdef LUT_MULT_SAT_EN
            rsh = RW'(rnd >>> FRAC);
            // In range when all bits from the IN_W sign bit upward agree.
            if ((rsh[RW-1:IN_W-1] == '0) || (rsh[RW-1:IN_W-1] == '1)) begin
                res_d[i*IN_W +: IN_W] = rsh[IN_W-1:0];
            end else begin
                sat_d[i] = 1'b1;
                res_d[i*IN_W +: IN_W] = rsh[RW-1] ? {1'b1, {(IN_W-1){1'b0}}}
                                                  : {1'b0, {(IN_W-1){1'b1}}};
            end
`else
            res_d[i*IN_W +: IN_W] = IN_W'(rnd >>> FRAC);
`endif
        end
    end

    logic [LANES*IN_W-1:0] m_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (adv3) begin
            m_valid_q <= v2_q;
            if (v2_q) begin
                m_data_q <= res_d;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

`ifdef LUT_MULT_SAT_EN
    logic [LANES-1:0] sat_q;
    logic [31:0]      sat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q     <= '0;
            sat_count <= '0;
        end else if (adv3 && v2_q) begin
            sat_q <= sat_d;
            if ((|sat_d) && (sat_count != '1)) begin
                sat_count <= sat_count + 32'd1;
            end
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_lut_mult_pipe.sv
// Self-checking bench for lut_mult_pipe: scoreboard of expected beats pushed on accept,
// popped and compared when the output handshake completes.

module tb_lut_mult_pipe;

    localparam int unsigned IN_W    = 32;
    localparam int unsigned CONST_W = 22;
    localparam int unsigned FRAC    = 15;
    localparam int unsigned LANES   = 8;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned AW      = 6;
    localparam int unsigned DW      = LANES * IN_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               coef_we;
    logic [AW-1:0]      coef_addr;
    logic [CONST_W-1:0] coef_wdata;
    logic               s_valid;
    logic               s_ready;
    logic [AW-1:0]      s_idx;
    logic [DW-1:0]      s_data;
    logic               m_valid;
    logic               m_ready;
    logic [DW-1:0]      m_data;
    logic [LANES-1:0]   sat_flag;

    lut_mult_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_idx      (s_idx),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [LANES-1:0] sat;
    } exp_t;

    exp_t               sb [$];
    logic [CONST_W-1:0] tab_m [DEPTH];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_out    = 0;
    int first_acc = -1;
    int first_out = -1;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] hold_data;
    logic [LANES-1:0] hold_sat;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers.
    function automatic void model(input logic [DW-1:0] d, input logic [CONST_W-1:0] c,
                                  output logic [DW-1:0] r, output logic [LANES-1:0] s);
        longint p, q;
        longint maxv, minv;
        maxv = 2147483647;
        minv = -maxv - 1;
        r = '0;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            p = longint'($signed(d[i*IN_W +: IN_W])) * longint'(c);
            q = (p + 64'sd16384) >>> FRAC;
`ifdef LUT_MULT_SAT_EN
            if (q > maxv) begin
                r[i*IN_W +: IN_W] = 32'h7FFF_FFFF;
                s[i] = 1'b1;
            end else if (q < minv) begin
                r[i*IN_W +: IN_W] = 32'h8000_0000;
                s[i] = 1'b1;
            end else begin
                r[i*IN_W +: IN_W] = q[31:0];
            end
`else
            r[i*IN_W +: IN_W] = q[31:0];
`endif
        end
    endfunction

    // One cycle: called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (rst_n && s_valid && s_ready) begin
            model(s_data, tab_m[s_idx], e.data, e.sat);
            sb.push_back(e);
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (rst_n && m_valid) begin
            if (first_out < 0) first_out = cyc;
            if (stall_prev) begin
                check_eq("hold_data", m_data, hold_data);
                check_eq("hold_sat", DW'(sat_flag), DW'(hold_sat));
            end
            if (m_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", DW'(m_valid), '0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_data", m_data, e.data);
                    check_eq("out_sat", DW'(sat_flag), DW'(e.sat));
                    n_out++;
                end
            end
            hold_data = m_data;
            hold_sat  = sat_flag;
        end
        stall_prev = rst_n && m_valid && !m_ready;
        if (coef_we) tab_m[coef_addr] = coef_wdata;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [CONST_W-1:0] v);
        s_valid    = 1'b0;
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] idx, input logic [DW-1:0] d);
        int start;
        int t;
        start   = n_acc;
        s_valid = 1'b1;
        s_idx   = idx;
        s_data  = d;
        t = 0;
        while (n_acc == start && t < 30) begin
            tick();
            t++;
        end
        if (n_acc == start) check_eq("send_timeout", DW'(n_acc), DW'(start + 1));
        s_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (n) tick();
    endtask

    function automatic logic [DW-1:0] lanes3(input logic [31:0] l0, input logic [31:0] l1,
                                             input logic [31:0] l2);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]  = l0;
        d[63:32] = l1;
        d[95:64] = l2;
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*IN_W +: IN_W] = $urandom();
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] d4 [12];
        logic [AW-1:0] i4 [12];
        int base, obase, t, stale;
        logic drop;

        rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        s_valid = 1'b0; s_idx = '0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_m_valid", DW'(m_valid), '0);
        check_eq("rst_m_data", m_data, '0);
        check_eq("rst_sat_flag", DW'(sat_flag), '0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_s_ready", DW'(s_ready), DW'(1));
        @(negedge clk);

        // Identity coefficient, 4 back-to-back beats, latency 3.
        write_coef(6'd0, 22'h8000);
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*IN_W +: IN_W] = 32'(i + 1);
        for (int b = 0; b < 4; b++) send(6'd0, d);
        drain(6);
        check_eq("t1_latency", DW'(first_out - first_acc), DW'(3));
        check_eq("t1_outs", DW'(n_out), DW'(4));

        // 0.5 with round half up, and zero coefficient.
        write_coef(6'd1, 22'h4000);
        send(6'd1, lanes3(32'd3, 32'hFFFF_FFFD, 32'd1));
        write_coef(6'd4, 22'h0);
        send(6'd4, rand_beat());
        drain(6);

        // 2.0 on the extremes: clamp or wrap.
        write_coef(6'd2, 22'h10000);
        send(6'd2, lanes3(32'h7FFF_FFFF, 32'h8000_0000, 32'd5));
        drain(6);
`ifdef LUT_MULT_SAT_EN
        check_eq("t3_sat_count", DW'(dut.sat_count), DW'(1));
`endif

        // Continuous input with an output stall.
        write_coef(6'd3, 22'h4000);
        for (int i = 0; i < 12; i++) begin
            d4[i] = rand_beat();
            i4[i] = AW'($urandom_range(0, 3));
        end
        base  = n_acc;
        obase = n_out;
        drop  = 1'b0;
        t     = 0;
        while ((n_acc - base) < 12 && t < 60) begin
            m_ready = !(t >= 5 && t <= 9);
            s_valid = 1'b1;
            s_data  = d4[n_acc - base];
            s_idx   = i4[n_acc - base];
            #1;
            if (!s_ready) drop = 1'b1;
            tick();
            t++;
        end
        drain(8);
        check_eq("t4_accepted", DW'(n_acc - base), DW'(12));
        check_eq("t4_outputs", DW'(n_out - obase), DW'(12));
        check_eq("t4_sready_drop", DW'(drop), DW'(1));
        check_eq("t4_sb_empty", DW'(sb.size()), '0);

        // Same-cycle table write and accept: old coefficient, then new.
        d = rand_beat();
        m_ready    = 1'b1;
        coef_we    = 1'b1;
        coef_addr  = 6'd3;
        coef_wdata = 22'h8000;
        s_valid    = 1'b1;
        s_idx      = 6'd3;
        s_data     = d;
        base       = n_acc;
        tick();
        coef_we = 1'b0;
        check_eq("t5_accept", DW'(n_acc - base), DW'(1));
        send(6'd3, d);
        drain(6);

        // Reset with 3 beats in flight.
        m_ready = 1'b0;
        for (int b = 0; b < 3; b++) send(6'd0, rand_beat());
        check_eq("t6_full", DW'(m_valid), DW'(1));
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_mvalid", DW'(m_valid), '0);
        check_eq("t6_async_mdata", m_data, '0);
        sb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        stale   = 0;
        repeat (6) begin
            #1;
            if (m_valid) stale++;
            tick();
        end
        check_eq("t6_stale", DW'(stale), '0);
        send(6'd1, lanes3(32'd3, 32'hFFFF_FFFD, 32'd1000));
        drain(6);
        check_eq("final_sb_empty", DW'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
